// File: rtl/store_commit_sched_if.sv
// store_commit_sched_if: groups the store-queue lanes, D-cache write port,
// MMIO port and management-op port of store_commit_sched.
//   slave  : the scheduler (consumes lanes, drives OUT_* requests)
//   master : the surrounding system (store queue, cache, MMIO, mgmt unit)
// Lane arrays are packed [lane][bits], lane 0 is the oldest store.
interface store_commit_sched_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MASK_W = 4
);
  logic [1:0]             IN_valid;
  logic [1:0][ADDR_W-1:0] IN_addr;
  logic [1:0][DATA_W-1:0] IN_data;
  logic [1:0][MASK_W-1:0] IN_wmask;
  logic [1:0]             OUT_stall;

  logic                   OUT_cValid;
  logic [ADDR_W-1:0]      OUT_cAddr;
  logic [DATA_W-1:0]      OUT_cData;
  logic [MASK_W-1:0]      OUT_cMask;
  logic                   IN_cStall;
  logic                   IN_cAck;

  logic                   OUT_mValid;
  logic [ADDR_W-1:0]      OUT_mAddr;
  logic [DATA_W-1:0]      OUT_mData;
  logic [MASK_W-1:0]      OUT_mMask;
  logic                   IN_mReady;
  logic                   IN_mDone;

  logic                   OUT_mgmt;
  logic [ADDR_W-1:0]      OUT_mgmtAddr;
  logic                   IN_mgmtDone;

  logic                   OUT_idle;

  modport slave (
    input  IN_valid, IN_addr, IN_data, IN_wmask, IN_cStall, IN_cAck,
           IN_mReady, IN_mDone, IN_mgmtDone,
    output OUT_stall, OUT_cValid, OUT_cAddr, OUT_cData, OUT_cMask,
           OUT_mValid, OUT_mAddr, OUT_mData, OUT_mMask,
           OUT_mgmt, OUT_mgmtAddr, OUT_idle
  );

  modport master (
    output IN_valid, IN_addr, IN_data, IN_wmask, IN_cStall, IN_cAck,
           IN_mReady, IN_mDone, IN_mgmtDone,
    input  OUT_stall, OUT_cValid, OUT_cAddr, OUT_cData, OUT_cMask,
           OUT_mValid, OUT_mAddr, OUT_mData, OUT_mMask,
           OUT_mgmt, OUT_mgmtAddr, OUT_idle
  );
endinterface

// File: rtl/store_commit_sched.sv
// store_commit_sched: drains committed stores from two ordered lanes.
// Cache stores go to one registered D-cache write port (same-word lane pairs
// merge into one write); MMIO stores and management ops (wmask==0) wait until
// every cache write has been acked, then issue on their own port.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : store_commit_sched_if.slave (lanes, stall, cache/MMIO/mgmt ports)
module store_commit_sched #(
  parameter int         ADDR_W   = 32,
  parameter int         DATA_W   = 32,
  parameter int         MASK_W   = 4,
  parameter int         MAX_OUT  = 4,
  parameter logic [3:0] MMIO_TAG = 4'hF
) (
  input  logic                clk,
  input  logic                rst,
  store_commit_sched_if.slave bus
);
  localparam int CW = $clog2(MAX_OUT + 1);

  typedef enum logic [2:0] {IDLE, DRAIN, M_REQ, M_WAIT, G_WAIT} state_t;

  state_t              state, state_n;
  logic [CW-1:0]       outstanding;
  logic                c_valid, m_valid, mgmt;
  logic [ADDR_W-1:0]   c_addr, p_addr;
  logic [DATA_W-1:0]   c_data, p_data, mrg_data;
  logic [MASK_W-1:0]   c_mask, p_mask;
  logic                p_mgmt;

  logic [1:0] is_mgmt, is_mmio, is_cache;
  logic       same_word, c_free, c_room;
  logic       take0, take1, load, merge, latch, set_m, clr_m, pulse;

  for (genvar l = 0; l < 2; l++) begin : g_cls
    assign is_mgmt[l]  = bus.IN_wmask[l] == '0;
    assign is_mmio[l]  = !is_mgmt[l] && (bus.IN_addr[l][ADDR_W-1 -: 4] == MMIO_TAG);
    assign is_cache[l] = !is_mgmt[l] && !is_mmio[l];
  end

  assign same_word = bus.IN_addr[0][ADDR_W-1:2] == bus.IN_addr[1][ADDR_W-1:2];
  assign c_free    = !c_valid || !bus.IN_cStall;
  // Room is judged on the pre-ack count; an ack only frees a slot next cycle.
  assign c_room    = outstanding < CW'(MAX_OUT);

  // Byte merge: lane 1 is younger, so its bytes override lane 0.
  always_comb begin
    mrg_data = bus.IN_data[0];
    for (int b = 0; b < MASK_W; b++)
      if (merge && bus.IN_wmask[1][b]) mrg_data[b*8 +: 8] = bus.IN_data[1][b*8 +: 8];
  end

  always_comb begin
    state_n = state;
    take0 = 1'b0; take1 = 1'b0; load = 1'b0; merge = 1'b0;
    latch = 1'b0; set_m = 1'b0; clr_m = 1'b0; pulse = 1'b0;
    case (state)
      IDLE: if (bus.IN_valid[0]) begin
        if (is_cache[0]) begin
          if (c_free && c_room) begin
            load  = 1'b1;
            take0 = 1'b1;
            if (bus.IN_valid[1] && is_cache[1] && same_word) begin
              merge = 1'b1;
              take1 = 1'b1;
            end
          end
        end else begin
          latch   = 1'b1;
          take0   = 1'b1;
          state_n = DRAIN;
        end
      end
      // Serialise behind every cache write, including one still in OUT_c*.
      DRAIN: if (outstanding == '0 && !c_valid) begin
        if (p_mgmt) begin
          pulse   = 1'b1;
          state_n = G_WAIT;
        end else begin
          set_m   = 1'b1;
          state_n = M_REQ;
        end
      end
      M_REQ: if (bus.IN_mReady) begin
        clr_m   = 1'b1;
        state_n = bus.IN_mDone ? IDLE : M_WAIT;
      end
      M_WAIT: if (bus.IN_mDone) state_n = IDLE;
      G_WAIT: if (bus.IN_mgmtDone) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Lane 1 can never be consumed when lane 0 is not.
  always_comb begin
    bus.OUT_stall[0] = rst || (state != IDLE) || (bus.IN_valid[0] && !take0);
    bus.OUT_stall[1] = bus.OUT_stall[0] || (bus.IN_valid[1] && !take1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      outstanding <= '0;
      c_valid     <= 1'b0;
      m_valid     <= 1'b0;
      mgmt        <= 1'b0;
      c_addr      <= '0;
      c_data      <= '0;
      c_mask      <= '0;
      p_addr      <= '0;
      p_data      <= '0;
      p_mask      <= '0;
      p_mgmt      <= 1'b0;
    end else begin
      state <= state_n;
      if (load && !bus.IN_cAck)
        outstanding <= outstanding + CW'(1);
      else if (!load && bus.IN_cAck && outstanding != '0)
        outstanding <= outstanding - CW'(1);

      if (load) begin
        c_valid <= 1'b1;
        c_addr  <= {bus.IN_addr[0][ADDR_W-1:2], 2'b00};
        c_data  <= mrg_data;
        c_mask  <= bus.IN_wmask[0] | (merge ? bus.IN_wmask[1] : '0);
      end else if (!bus.IN_cStall) begin
        c_valid <= 1'b0;
      end

      if (latch) begin
        p_addr <= bus.IN_addr[0];
        p_data <= bus.IN_data[0];
        p_mask <= bus.IN_wmask[0];
        p_mgmt <= is_mgmt[0];
      end

      if (set_m)      m_valid <= 1'b1;
      else if (clr_m) m_valid <= 1'b0;
      mgmt <= pulse;
    end
  end

  // An ack with nothing outstanding means the cache and scheduler disagree.
  always_ff @(posedge clk)
    if (!rst && bus.IN_cAck) assert (outstanding != '0);

  assign bus.OUT_cValid   = c_valid;
  assign bus.OUT_cAddr    = c_addr;
  assign bus.OUT_cData    = c_data;
  assign bus.OUT_cMask    = c_mask;
  assign bus.OUT_mValid   = m_valid;
  assign bus.OUT_mAddr    = p_addr;
  assign bus.OUT_mData    = p_data;
  assign bus.OUT_mMask    = p_mask;
  assign bus.OUT_mgmt     = mgmt;
  assign bus.OUT_mgmtAddr = p_addr;
  assign bus.OUT_idle     = (state == IDLE) && (outstanding == '0) && !c_valid && !m_valid && !mgmt;
endmodule
